// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the 2-read/1-write register file.
package reg_file_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Request/response bundle between the pipeline and the register file.
// master = decode/writeback side, slave = register file.
interface reg_file_2r1w_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              ready;
  logic              rd0_en;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd0_data;
  logic              rd0_valid;
  logic              rd1_en;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  ready, rd0_data, rd0_valid, rd1_data, rd1_valid,
    output rd0_en, rd0_addr, rd1_en, rd1_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output ready, rd0_data, rd0_valid, rd1_data, rd1_valid,
    input  rd0_en, rd0_addr, rd1_en, rd1_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One registered read port: write-first bypass, zero-register masking
// and the data/valid output registers.
module reg_file_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic              take;
  logic              bypass_hit;
  logic              zero_hit;
  logic [DATA_W-1:0] data_nxt;

  // Select the value a read sampled this cycle must return.
  always_comb begin
    take       = run && rd_en;
    bypass_hit = wr_fire && (wr_addr == rd_addr);
    zero_hit   = ZERO_REG && (rd_addr == '0);
    if (zero_hit)
      data_nxt = '0;
    else if (bypass_hit)
      data_nxt = wr_data;
    else
      data_nxt = mem_data;
  end

  // Output registers: data holds between reads, valid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= take;
      if (take)
        rd_data <= data_nxt;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised 2-read/1-write register file with self-clearing init.
//
// state   | meaning
// RF_INIT | clearing entry[ptr] each cycle, all requests ignored
// RF_RUN  | array initialised, ready = 1, reads/writes accepted
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b0
) (
  input logic               clk,
  input logic               rst,
  reg_file_2r1w_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              run;
  logic              init_we;
  logic              wr_fire;

  // State and clear-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: walk the pointer once across the array, then run forever.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      RF_INIT: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(DEPTH - 1))
          state_nxt = RF_RUN;
      end
      RF_RUN:  state_nxt = RF_RUN;
      default: state_nxt = RF_INIT;
    endcase
  end

  // State-decoded controls and write qualification.
  always_comb begin
    run     = (state == RF_RUN);
    init_we = (state == RF_INIT);
    wr_fire = run && bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
  end

  assign bus.ready = run;

  // Storage: zero fill during init, qualified writes afterwards; a write in
  // a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we)
        mem[ptr] <= '0;
      else if (wr_fire)
        mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd0 (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rd_en    (bus.rd0_en),
    .rd_addr  (bus.rd0_addr),
    .wr_fire  (wr_fire),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .mem_data (mem[bus.rd0_addr]),
    .rd_data  (bus.rd0_data),
    .rd_valid (bus.rd0_valid)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd1 (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rd_en    (bus.rd1_en),
    .rd_addr  (bus.rd1_addr),
    .wr_fire  (wr_fire),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .mem_data (mem[bus.rd1_addr]),
    .rd_data  (bus.rd1_data),
    .rd_valid (bus.rd1_valid)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 driven in lockstep and compared against an array model.
module tb_reg_file_2r1w;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rd0_en = 1'b0, rd1_en = 1'b0, wr_en = 1'b0;
  logic [3:0]  rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
  logic [31:0] wr_data = '0;

  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

  assign bus0.rd0_en = rd0_en;  assign bus1.rd0_en = rd0_en;
  assign bus0.rd0_addr = rd0_addr; assign bus1.rd0_addr = rd0_addr;
  assign bus0.rd1_en = rd1_en;  assign bus1.rd1_en = rd1_en;
  assign bus0.rd1_addr = rd1_addr; assign bus1.rd1_addr = rd1_addr;
  assign bus0.wr_en = wr_en;    assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  reg_file_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: index [dut] where dut 1 has the zero register.
  logic [31:0] m_mem [2][16];
  logic [31:0] m_d   [2][2];
  logic        m_v   [2][2];
  logic        m_ready;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [3:0] a);
    if (d == 1 && a == 4'd0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[d][a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin m_d[d][p] = '0; m_v[d][p] = 1'b0; end
    end else if (!m_ready) begin
      m_cnt++;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) m_v[d][p] = 1'b0;
      if (m_cnt == 16) begin
        m_ready = 1'b1;
        for (int d = 0; d < 2; d++)
          for (int a = 0; a < 16; a++) m_mem[d][a] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rd0_en) m_d[d][0] = model_read(d, rd0_addr);
        if (rd1_en) m_d[d][1] = model_read(d, rd1_addr);
        m_v[d][0] = rd0_en;
        m_v[d][1] = rd1_en;
        if (wr_en && !(d == 1 && wr_addr == 4'd0)) m_mem[d][wr_addr] = wr_data;
      end
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready_d0", {31'b0, bus0.ready}, {31'b0, m_ready});
    chk("ready_d1", {31'b0, bus1.ready}, {31'b0, m_ready});
    chk("v0_d0", {31'b0, bus0.rd0_valid}, {31'b0, m_v[0][0]});
    chk("v1_d0", {31'b0, bus0.rd1_valid}, {31'b0, m_v[0][1]});
    chk("v0_d1", {31'b0, bus1.rd0_valid}, {31'b0, m_v[1][0]});
    chk("v1_d1", {31'b0, bus1.rd1_valid}, {31'b0, m_v[1][1]});
    chk("d0_d0", bus0.rd0_data, m_d[0][0]);
    chk("d1_d0", bus0.rd1_data, m_d[0][1]);
    chk("d0_d1", bus1.rd0_data, m_d[1][0]);
    chk("d1_d1", bus1.rd1_data, m_d[1][1]);
  endtask

  task automatic idle();
    rd0_en = 1'b0; rd1_en = 1'b0; wr_en = 1'b0;
  endtask

  // Counts edges from reset release until ready; expects exactly 16.
  task automatic wait_ready(input string nm, input logic no_valid);
    int n = 0;
    while (bus0.ready !== 1'b1 && n < 40) begin
      step();
      n++;
      if (no_valid)
        chk({nm, "_novalid"}, {30'b0, bus0.rd0_valid, bus0.rd1_valid}, 32'h0);
    end
    chk(nm, n, 32'd16);
  endtask

  typedef struct {
    logic        r0e; logic [3:0] r0a;
    logic        r1e; logic [3:0] r1a;
    logic        we;  logic [3:0] wa; logic [31:0] wd;
    logic        ev;
    logic [31:0] ed0, ed1, ez0, ez1;
  } vec_t;

  function automatic vec_t mk(input logic r0e, input logic [3:0] r0a,
                              input logic r1e, input logic [3:0] r1a,
                              input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic ev, input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic [31:0] ez0, input logic [31:0] ez1);
    vec_t v;
    v.r0e = r0e; v.r0a = r0a; v.r1e = r1e; v.r1a = r1a;
    v.we = we; v.wa = wa; v.wd = wd; v.ev = ev;
    v.ed0 = ed0; v.ed1 = ed1; v.ez0 = ez0; v.ez1 = ez1;
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    tbl[0] = mk(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[1] = mk(0, 0, 0, 0, 1, 9, 32'h12345678, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[2] = mk(1, 5, 1, 9, 0, 0, 32'h0, 1, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678);
    tbl[3] = mk(1, 3, 1, 3, 1, 3, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    tbl[4] = mk(1, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    tbl[5] = mk(1, 0, 1, 0, 0, 0, 32'h0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    tbl[6] = mk(1, 3, 1, 5, 1, 5, 32'h11111111, 1, 32'hA5A5A5A5, 32'h11111111, 32'hA5A5A5A5, 32'h11111111);
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'hA5A5A5A5, 32'h11111111, 32'hA5A5A5A5, 32'h11111111);

    // Reset for two cycles, then release and time the init sweep.
    rst = 1'b1;
    step();
    chk("rst_ready", {31'b0, bus0.ready}, 32'h0);
    step();
    rst = 1'b0;
    wait_ready("init_latency", 1'b0);

    // Every entry reads zero after init, on both ports.
    for (int a = 0; a < 16; a++) begin
      rd0_en = 1'b1; rd0_addr = 4'(a);
      rd1_en = 1'b1; rd1_addr = 4'(15 - a);
      step();
      chk("init_zero_v", {30'b0, bus0.rd0_valid, bus0.rd1_valid}, 32'h3);
      chk("init_zero_d", bus0.rd0_data | bus0.rd1_data, 32'h0);
    end
    idle();
    step();

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      rd0_en = tbl[i].r0e; rd0_addr = tbl[i].r0a;
      rd1_en = tbl[i].r1e; rd1_addr = tbl[i].r1a;
      wr_en  = tbl[i].we;  wr_addr  = tbl[i].wa; wr_data = tbl[i].wd;
      step();
      chk($sformatf("vec%0d_v", i), {30'b0, bus0.rd0_valid, bus0.rd1_valid},
          tbl[i].ev ? 32'h3 : 32'h0);
      chk($sformatf("vec%0d_d0", i), bus0.rd0_data, tbl[i].ed0);
      chk($sformatf("vec%0d_d1", i), bus0.rd1_data, tbl[i].ed1);
      chk($sformatf("vec%0d_z0", i), bus1.rd0_data, tbl[i].ez0);
      chk($sformatf("vec%0d_z1", i), bus1.rd1_data, tbl[i].ez1);
    end
    idle();

    // Requests held high through reset and init must neither read nor write.
    rd0_en = 1'b1; rd0_addr = 4'd7; rd1_en = 1'b1; rd1_addr = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h00000BAD;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_ready("init_busy_latency", 1'b1);
    wr_en = 1'b0;
    step();
    chk("init_busy_rd", bus0.rd0_data | bus0.rd1_data, 32'h0);
    chk("init_busy_v", {30'b0, bus0.rd0_valid, bus0.rd1_valid}, 32'h3);
    idle();

    // Reset in the middle of a read.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
    step();
    wr_en = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd7; rd1_en = 1'b1; rd1_addr = 4'd7;
    step();
    chk("pre_rst_rd", bus0.rd0_data, 32'h77);
    rst = 1'b1;
    step();
    chk("mid_rst_v", {30'b0, bus0.rd0_valid, bus0.rd1_valid}, 32'h0);
    chk("mid_rst_d", bus0.rd0_data | bus0.rd1_data, 32'h0);
    idle();
    step();
    rst = 1'b0;
    wait_ready("mid_rst_latency", 1'b0);
    rd0_en = 1'b1; rd0_addr = 4'd7; rd1_en = 1'b1; rd1_addr = 4'd7;
    step();
    chk("post_rst_rd", bus0.rd0_data | bus0.rd1_data, 32'h0);
    idle();

    // Random traffic with occasional resets; narrow address range forces hits.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      rd0_en   = $urandom_range(0, 1) == 1;
      rd1_en   = $urandom_range(0, 1) == 1;
      wr_en    = $urandom_range(0, 2) != 0;
      rd0_addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rd1_addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wr_addr  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wr_data  = $urandom;
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
